// File: rtl/gbuf_read_streamer.sv
// gbuf_read_streamer
// Read-side engine for the global buffer. Each start pulse launches one job
// of `count` words, beginning at `base_addr` and advancing by `stride`. The
// engine drives the buffer read address and captures the combinational read
// data into a registered valid/ready stream toward the PE array.
//
// Ports:
//   clk, rst          - clock (rising edge), synchronous active-high reset
//   start             - one-cycle job request, honoured only in IDLE
//   base_addr, count, stride - job descriptor sampled with start
//   raddr / rdata     - buffer read address out, same-cycle read data in
//   out_data/out_valid/out_ready - output stream (data and valid registered)
//   busy, done        - job status toward the top-level controller
//
// Build option:
//   GBUF_RD_WRAP_EN   - when defined, addresses wrap modulo DEPTH instead of
//                       modulo 2**ADDR_WIDTH (circular buffers of any depth).

module gbuf_read_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic [ADDR_WIDTH-1:0] stride,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // A buffer deeper than the address space cannot be addressed.
    localparam longint ADDR_SPAN = longint'(1) << ADDR_WIDTH;
    generate
        if (DEPTH > ADDR_SPAN || DEPTH < 1) begin : g_depth_check
            $error("gbuf_read_streamer: DEPTH must be in 1..2**ADDR_WIDTH");
        end
    endgenerate

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [CNT_WIDTH-1:0]  remaining_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  out_valid_reg;
    logic [ADDR_WIDTH-1:0] addr_step;
    logic                  load;
    logic                  xfer;

    // A new word is captured whenever the output register is empty or is
    // being emptied this cycle, which gives one word per cycle at full rate.
    assign load = (state_reg == STREAM) && (!out_valid_reg || out_ready);
    assign xfer = out_valid_reg && out_ready;

`ifdef GBUF_RD_WRAP_EN
    // The sum is formed one bit wider so a carry past 2**ADDR_WIDTH is still
    // seen as ">= DEPTH"; with base and stride below DEPTH one subtraction
    // is always enough.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    logic [ADDR_WIDTH:0] sum_full;
    logic [ADDR_WIDTH:0] sum_wrap;
    assign sum_full  = {1'b0, addr_reg} + {1'b0, stride};
    assign sum_wrap  = sum_full - DEPTH_EXT;
    assign addr_step = (sum_full < DEPTH_EXT) ? sum_full[ADDR_WIDTH-1:0]
                                              : sum_wrap[ADDR_WIDTH-1:0];
`else
    assign addr_step = addr_reg + stride;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (count != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (load && remaining_reg == CNT_WIDTH'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            STREAM, DRAIN: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: address/count bookkeeping and the output stream register.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) begin
                addr_reg      <= base_addr;
                remaining_reg <= count;
            end
            if (load) begin
                out_data_reg  <= rdata;
                out_valid_reg <= 1'b1;
                addr_reg      <= addr_step;
                remaining_reg <= remaining_reg - CNT_WIDTH'(1);
            end else if (xfer) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign raddr     = addr_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

endmodule
